// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// FSM state encoding and the default operand width.
package seq_divider_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: WIDTH+1-bit trial subtract
// built as a ripple adder with B inverted and carry-in 1.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             din,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] rem_nxt,
    output logic             qbit
);

    logic [WIDTH:0] x;
    logic [WIDTH:0] y;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] c;

    assign x    = {rem, din};
    assign y    = ~{1'b0, b};
    assign c[0] = 1'b1;

    // Ripple-carry full adders; the last carry-out is not needed.
    for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
        assign sum[i] = x[i] ^ y[i] ^ c[i];
        if (i < WIDTH) begin : g_cy
            assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    // A clear sign bit means the trial fits; otherwise restore.
    // The restored value always fits WIDTH bits because rem < b.
    assign qbit    = ~sum[WIDTH];
    assign rem_nxt = qbit ? sum[WIDTH-1:0] : x[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// start/done handshake; divide-by-zero finishes in a single cycle.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] qsr;
    logic [WIDTH-1:0] bq;
    logic [WIDTH-1:0] rem_nxt;
    logic [CW-1:0]    cnt;
    logic             qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .din     (qsr[WIDTH-1]),
        .b       (bq),
        .rem_nxt (rem_nxt),
        .qbit    (qbit)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic: zero divisor skips RUN entirely.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = (B == '0) ? DONE : RUN;
            RUN:  if (cnt == LAST) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-subtract steps, result load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= '0;
            qsr <= '0;
            bq  <= '0;
            cnt <= '0;
            Q   <= '0;
            R   <= '0;
            dbz <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bq <= B;
                        if (B == '0) begin
                            Q   <= '1;
                            R   <= A;
                            dbz <= 1'b1;
                        end else begin
                            rem <= '0;
                            qsr <= A;
                            cnt <= '0;
                            dbz <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem <= rem_nxt;
                    qsr <= {qsr[WIDTH-2:0], qbit};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        Q <= {qsr[WIDTH-2:0], qbit};
                        R <= rem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status decode straight from the state.
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against an arithmetic
// reference model (integer / and %).
module tb_seq_divider;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [7:0] A     = '0;
    logic [7:0] B     = '0;
    logic [7:0] Q;
    logic [7:0] R;
    logic       busy;
    logic       done;
    logic       dbz;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz)
    );

    function automatic logic [7:0] ref_q(input int a, input int b);
        return (b == 0) ? 8'hFF : 8'(a / b);
    endfunction

    function automatic logic [7:0] ref_r(input int a, input int b);
        return (b == 0) ? 8'(a) : 8'(a % b);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE; returns edges-to-done and busy cycles.
    // Ends back in IDLE with the result still held on Q/R/dbz.
    task automatic run_op(input int a, input int b,
                          output int lat, output int nbusy);
        A = 8'(a);
        B = 8'(b);
        start = 1'b1;
        tick;
        start = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
        lat = -1;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            if (busy) nbusy++;
            tick;
        end
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        tick;
        tick;
        total++;
        if ({Q, R, busy, done, dbz} !== 19'd0) begin
            bad++;
            $display("FAIL reset_hold got=%h want=0", {Q, R, busy, done, dbz});
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            total++;
            if ({Q, R, busy, done, dbz} !== 19'd0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%h want=0",
                         i, {Q, R, busy, done, dbz});
            end
        end
    endtask

    task automatic test_basic;
        int ta [4] = '{250, 9, 255, 255};
        int tb [4] = '{7, 250, 1, 255};
        int lat;
        int nb;
        for (int k = 0; k < 4; k++) begin
            run_op(ta[k], tb[k], lat, nb);
            total++;
            if ({Q, R, dbz} !== {ref_q(ta[k], tb[k]), ref_r(ta[k], tb[k]), 1'b0}) begin
                bad++;
                $display("FAIL basic %0d/%0d got q=%0d r=%0d dbz=%0d want q=%0d r=%0d dbz=0",
                         ta[k], tb[k], Q, R, dbz, ref_q(ta[k], tb[k]), ref_r(ta[k], tb[k]));
            end
            total++;
            if (lat !== 8 || nb !== 8) begin
                bad++;
                $display("FAIL basic_latency %0d/%0d got lat=%0d busy=%0d want 8/8",
                         ta[k], tb[k], lat, nb);
            end
        end
    endtask

    task automatic test_dbz;
        int lat;
        int nb;
        run_op(100, 0, lat, nb);
        total++;
        if ({Q, R, dbz} !== {8'd255, 8'd100, 1'b1}) begin
            bad++;
            $display("FAIL dbz_result got q=%0d r=%0d dbz=%0d want q=255 r=100 dbz=1",
                     Q, R, dbz);
        end
        total++;
        if (lat !== 0 || nb !== 0) begin
            bad++;
            $display("FAIL dbz_latency got lat=%0d busy=%0d want 0/0", lat, nb);
        end
        run_op(10, 3, lat, nb);
        total++;
        if ({Q, R, dbz} !== {8'd3, 8'd1, 1'b0} || lat !== 8) begin
            bad++;
            $display("FAIL dbz_clear got q=%0d r=%0d dbz=%0d lat=%0d want 3/1/0/8",
                     Q, R, dbz, lat);
        end
    endtask

    task automatic test_ignore_start;
        int lat = -1;
        A = 8'd250;
        B = 8'd7;
        start = 1'b1;
        tick;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            start = (i == 2 || i == 7);
            A = 8'd1;
            B = 8'd1;
            tick;
        end
        start = 1'b0;
        total++;
        if (lat !== 8 || Q !== 8'd35 || R !== 8'd5) begin
            bad++;
            $display("FAIL ignore_start got lat=%0d q=%0d r=%0d want 8/35/5", lat, Q, R);
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            total++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL ignore_idle cyc=%0d got busy=%0d done=%0d want 0/0",
                         i, busy, done);
            end
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int nb;
        bit seen = 1'b0;
        A = 8'd200;
        B = 8'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        tick;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({Q, R, busy, done, dbz} !== 19'd0) begin
            bad++;
            $display("FAIL reset_mid got=%h want=0", {Q, R, busy, done, dbz});
        end
        tick;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done || busy) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_quiet got activity=%0d want 0", seen);
        end
        run_op(200, 3, lat, nb);
        total++;
        if (Q !== 8'd66 || R !== 8'd2 || lat !== 8) begin
            bad++;
            $display("FAIL reset_mid_rerun got q=%0d r=%0d lat=%0d want 66/2/8", Q, R, lat);
        end
    endtask

    task automatic test_back_to_back;
        int n = 6;
        int qa [6];
        int qb [6];
        int lat;
        for (int k = 0; k < n; k++) begin
            qa[k] = int'($urandom_range(0, 255));
            qb[k] = int'($urandom_range(1, 255));
        end
        A = 8'(qa[0]);
        B = 8'(qb[0]);
        start = 1'b1;
        tick;
        for (int k = 0; k < n; k++) begin
            lat = -1;
            for (int i = 0; i < 20; i++) begin
                if (done) begin
                    lat = i;
                    break;
                end
                tick;
            end
            total++;
            if (lat !== 8 || Q !== ref_q(qa[k], qb[k]) || R !== ref_r(qa[k], qb[k])) begin
                bad++;
                $display("FAIL b2b %0d/%0d got lat=%0d q=%0d r=%0d want 8 q=%0d r=%0d",
                         qa[k], qb[k], lat, Q, R, ref_q(qa[k], qb[k]), ref_r(qa[k], qb[k]));
            end
            if (k < n - 1) begin
                A = 8'(qa[k+1]);
                B = 8'(qb[k+1]);
            end else begin
                start = 1'b0;
            end
            tick;
            total++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL b2b_gap got busy=%0d done=%0d want 0/0", busy, done);
            end
            tick;
            if (k < n - 1) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_restart got busy=%0d want 1", busy);
                end
            end
        end
        start = 1'b0;
        tick;
    endtask

    task automatic test_sweep;
        int bl [7] = '{1, 2, 3, 7, 16, 250, 255};
        int lat;
        int nb;
        int a;
        int b;
        for (int n = 0; n < 256 * 7 + 64; n++) begin
            if (n < 256 * 7) begin
                a = n / 7;
                b = bl[n % 7];
            end else begin
                a = int'($urandom_range(0, 255));
                b = int'($urandom_range(0, 255));
            end
            run_op(a, b, lat, nb);
            total++;
            if (Q !== ref_q(a, b) || R !== ref_r(a, b) || dbz !== (b == 0)) begin
                bad++;
                $display("FAIL sweep %0d/%0d got q=%0d r=%0d dbz=%0d want q=%0d r=%0d",
                         a, b, Q, R, dbz, ref_q(a, b), ref_r(a, b));
            end
            if (b != 0) begin
                total++;
                if (int'(Q) * b + int'(R) != a || int'(R) >= b) begin
                    bad++;
                    $display("FAIL sweep_invariant %0d/%0d got q=%0d r=%0d", a, b, Q, R);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic;
        test_dbz;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        test_sweep;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential unsigned shift-subtract (restoring) divider.
- Counterpart to the combinational 8-bit adder datapath: it undoes the arithmetic, producing quotient and remainder from the dividend and divisor.
- Computes one quotient bit per clock and uses a start/done handshake.
- Sits beside the adder in the lab datapath as its first multi-cycle arithmetic block.

Parameters:
- WIDTH, 8, operand/result width in bits; latency equals WIDTH cycles.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high; one clock domain only.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  dividend; captured on the accepted start.
- B  input  WIDTH  divisor; captured on the accepted start.
- Q  output  WIDTH  quotient, registered.
- R  output  WIDTH  remainder, registered.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; Q/R/dbz valid from this cycle.
- dbz  output  1  divide-by-zero flag for the current result.

Behaviour:
- Reset (async, any state, including mid-RUN):
  - state=IDLE; Q=0, R=0, busy=0, done=0, dbz=0; bit counter=0.
  - Any operation in flight is discarded.
  - No done pulse follows reset.
- States and transitions:
  - IDLE: start=0 stays in IDLE. start=1 latches A and B.
    - If B==0: go to DONE; Q=all ones, R=A, dbz=1.
    - Else: go to RUN; partial remainder=0, quotient shift reg=A, count=0, dbz=0.
  - RUN, one step per edge:
    - trial = {rem[WIDTH-1:0], qsr[WIDTH-1]} - {1'b0, B}, computed WIDTH+1 bits wide.
    - If trial is non-negative (MSB=0): rem=trial, shift 1 into the qsr LSB.
    - Else: rem={rem,qsr MSB} (restore), shift 0 into the qsr LSB.
    - count increments each step. On the step where count==WIDTH-1, go to DONE and load Q=qsr (final) and R=rem.
  - DONE: lasts exactly 1 cycle, then IDLE.
- Output decode:
  - done = (state==DONE); busy = (state==RUN).
- Latency:
  - start accepted at edge k; normal case: done high in the cycle after edge k+WIDTH (8 for the default).
  - Divide-by-zero: done high in the cycle after edge k.
- Holding and ignoring:
  - Q, R and dbz hold their values after done until the next accepted start updates them.
  - Q/R are not cleared when a new operation starts; they change only at DONE entry.
  - start is ignored while in RUN or DONE; it is not queued.
  - start held continuously gives back-to-back operations, each re-sampling A/B in IDLE. One idle cycle separates done from the next busy.
  - A and B may change freely after acceptance without affecting the result.
- Arithmetic:
  - Unsigned only.
  - Invariant when dbz=0: A == Q*B + R, with R < B.
  - The trial subtract is WIDTH+1 bits wide so the remainder never overflows, including B=2^WIDTH-1.

Decomposition:
- Shared include file: state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2; default WIDTH.
- One natural sub-module, div_step:
  - Combinational, WIDTH+1-bit trial subtract plus restore mux.
  - Inputs: rem, next dividend bit, B. Outputs: new rem, quotient bit.
  - Reuses the team's ripple adder style, fed with B inverted and carry-in 1.
- Top level holds the FSM, counter and registers.

Test Plan:
- Reset then idle: hold rst 2 cycles, start=0 for 10 cycles -> Q=0, R=0, busy=0, done=0, dbz=0 throughout.
- Basic and boundary values; each done pulse arrives exactly 8 cycles after start, with busy high for 8 cycles:
  - A=250, B=7, start 1 cycle -> Q=35, R=5, dbz=0.
  - A=9, B=250 -> Q=0, R=9.
  - A=255, B=1 -> Q=255, R=0.
  - A=255, B=255 -> Q=1, R=0.
- Divide by zero: A=100, B=0 -> done one cycle after start, Q=255, R=100, dbz=1, busy never high. A following A=10, B=3 clears dbz -> Q=3, R=1.
- start pulsed again with A=1, B=1 at cycles 3 and 8 of a RUN for 250/7 -> both ignored; result Q=35, R=5; then IDLE.
- rst asserted mid-RUN (cycle 4 of 200/3) -> outputs zero immediately, no done pulse. Next start 200/3 -> Q=66, R=2.
- Random sweep: all A in 0..255 against B in {1,2,3,7,16,250,255} -> A == Q*B+R and R<B every time.
